// File: rtl/cond_flag_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cond_flag_sequencer
// Brief    : NZCV status owner, ARM condition evaluation for ID, and flag
//            hazard sequencing (EXE forward/stall, multi-cycle flag wait).
// Revision : 1.0 - initial release
// ============================================================================
module cond_flag_sequencer #(
    parameter bit FWD        = 1'b1,
    parameter int MC_TIMEOUT = 16,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [3:0] id_cond,
    input  logic       id_s,
    output logic       id_cond_pass,
    output logic       id_stall,
    input  logic       mc_issue,
    input  logic       exe_wr_en,
    input  logic [3:0] exe_flags,
    input  logic       mc_done,
    input  logic [3:0] mc_flags,
    input  logic       flush,
    output logic [3:0] status,
    output logic       mc_err
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MC_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(MC_TIMEOUT - 1);
    localparam logic [3:0]       c_cond_al  = 4'b1110;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_status, w_status_nxt;
    logic             r_mc_err, w_mc_err_nxt;
    logic [3:0]       w_eval_flags;

    // flags = {N,Z,C,V}
    function automatic logic f_cond_true(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            4'b0000: f_cond_true = z;
            4'b0001: f_cond_true = ~z;
            4'b0010: f_cond_true = c;
            4'b0011: f_cond_true = ~c;
            4'b0100: f_cond_true = n;
            4'b0101: f_cond_true = ~n;
            4'b0110: f_cond_true = v;
            4'b0111: f_cond_true = ~v;
            4'b1000: f_cond_true = c & ~z;
            4'b1001: f_cond_true = ~c | z;
            4'b1010: f_cond_true = (n == v);
            4'b1011: f_cond_true = (n != v);
            4'b1100: f_cond_true = ~z & (n == v);
            4'b1101: f_cond_true = z | (n != v);
            default: f_cond_true = 1'b1;
        endcase
    endfunction

    assign w_eval_flags = (FWD && exe_wr_en) ? exe_flags : r_status;

    always_comb begin
        id_stall     = 1'b0;
        id_cond_pass = 1'b0;
        if (!flush) begin
            id_cond_pass = f_cond_true(id_cond, w_eval_flags);
            if (r_state == ST_MC_WAIT)
                // AL writers are held too, so the late mc write cannot clobber them
                id_stall = id_valid & ((id_cond != c_cond_al) | id_s);
            else
                id_stall = id_valid & ~FWD & exe_wr_en & (id_cond != c_cond_al);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_status_nxt = r_status;
        w_mc_err_nxt = r_mc_err;

        if (exe_wr_en)
            w_status_nxt = exe_flags;
        else if ((r_state == ST_MC_WAIT) && mc_done)
            w_status_nxt = mc_flags;

        case (r_state)
            ST_RUN: begin
                if (mc_issue) begin
                    w_state_nxt = ST_MC_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_MC_WAIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (mc_done) begin
                    w_state_nxt = ST_RUN;
                end else if (r_cnt == c_last_cnt) begin
                    w_state_nxt  = ST_RUN;
                    w_mc_err_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_RUN;
            r_cnt    <= '0;
            r_status <= 4'b0000;
            r_mc_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_status <= w_status_nxt;
            r_mc_err <= w_mc_err_nxt;
        end
    end

    assign status = r_status;
    assign mc_err = r_mc_err;

endmodule
`default_nettype wire
